game_controller: RTL and testbench

GAME_CONTROLLER -- requirements
Module: game_controller

---
 rtl/game_controller.sv | 154 +++++++++++++++
 tb/tb_game_controller.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/game_controller.sv
// ============================================================================
// game_controller
//   Falling-letter game FSM: staggered column launch, per-column respawn,
//   saturating score, lives with game-over, restart on start.
//   Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module game_controller #(
  parameter int NUM_COLUMNS    = 3,
  parameter int SCORE_WIDTH    = 8,
  parameter int STAGGER_CYCLES = 25_000_000,
  parameter int START_LIVES    = 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [NUM_COLUMNS-1:0] correct,
  input  logic [NUM_COLUMNS-1:0] game_over,
  output logic [NUM_COLUMNS-1:0] column_reset,
  output logic [SCORE_WIDTH-1:0] score,
  output logic [3:0]             lives,
  output logic [1:0]             state
);

  // Counter must reach the release point of the last column.
  localparam int LAUNCH_MAX = (NUM_COLUMNS - 1) * STAGGER_CYCLES;
  localparam int CNT_W      = (LAUNCH_MAX > 0) ? $clog2(LAUNCH_MAX + 1) : 1;
  // Popcount width for up to NUM_COLUMNS simultaneous pulses.
  localparam int CW         = $clog2(NUM_COLUMNS + 1);
  // Score sum is one bit wider than the widest operand so overflow is visible.
  localparam int SUM_W      = ((SCORE_WIDTH > CW) ? SCORE_WIDTH : CW) + 1;
  localparam int LW         = (CW > 4) ? CW : 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    PLAY   = 2'd2,
    OVER   = 2'd3
  } state_t;

  state_t                 fsm;
  logic [CNT_W-1:0]       cnt;
  logic [NUM_COLUMNS-1:0] released;
  logic [1:0]             rst_sync;
  logic                   rst_n_sync;

  logic [NUM_COLUMNS-1:0] hits;
  logic [NUM_COLUMNS-1:0] misses;
  logic [NUM_COLUMNS-1:0] rel_now;
  logic [NUM_COLUMNS-1:0] rel_next;
  logic [CW-1:0]          hit_cnt;
  logic [CW-1:0]          miss_cnt;
  logic [SUM_W-1:0]       score_sum;
  logic [SCORE_WIDTH-1:0] score_next;
  logic [3:0]             lives_next;

  assign state = fsm;

  // Reset asserts immediately but releases the FSM only after two clean edges.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n_sync = rst_sync[1];

  // Pulse qualification, launch release decode, score and lives arithmetic.
  always_comb begin
    hits      = '0;
    misses    = '0;
    rel_now   = '0;
    rel_next  = released;
    hit_cnt   = '0;
    miss_cnt  = '0;
    score_sum = '0;
    score_next = score;
    lives_next = lives;

    // A column held in reset ignores its pulses; a miss beats a match.
    misses = game_over & ~column_reset;
    hits   = correct & ~column_reset & ~game_over;

    for (int i = 0; i < NUM_COLUMNS; i++) begin
      rel_now[i] = (cnt == CNT_W'(i * STAGGER_CYCLES));
      hit_cnt    = hit_cnt + CW'(hits[i]);
      miss_cnt   = miss_cnt + CW'(misses[i]);
    end

    if (fsm == LAUNCH) rel_next = released | rel_now;

    score_sum = SUM_W'(score) + SUM_W'(hit_cnt);
    if (score_sum > SUM_W'({SCORE_WIDTH{1'b1}}))
      score_next = {SCORE_WIDTH{1'b1}};
    else
      score_next = score_sum[SCORE_WIDTH-1:0];

    // Lives floor at zero; when not flooring, miss_cnt < lives <= 15 fits 4 bits.
    if (LW'(miss_cnt) >= LW'(lives))
      lives_next = 4'd0;
    else
      lives_next = lives - 4'(miss_cnt);
  end

  // Game FSM; every output is a register updated here.
  always_ff @(posedge clock or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      fsm          <= IDLE;
      column_reset <= '1;
      score        <= '0;
      lives        <= '0;
      cnt          <= '0;
      released     <= '0;
    end else if (start) begin
      // Start (re)initialises from any state and overrides same-cycle pulses.
      fsm          <= LAUNCH;
      column_reset <= '1;
      score        <= '0;
      lives        <= 4'(START_LIVES);
      cnt          <= '0;
      released     <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          column_reset <= '1;
        end
        LAUNCH, PLAY: begin
          score <= score_next;
          lives <= lives_next;
          if (lives_next == 4'd0) begin
            // Out of lives: hold every column, no respawn pulses.
            fsm          <= OVER;
            column_reset <= '1;
            released     <= '0;
          end else begin
            // Unreleased columns stay held; hit/missed columns pulse once.
            column_reset <= ~rel_next | hits | misses;
            released     <= rel_next;
            if (fsm == LAUNCH) begin
              cnt <= cnt + CNT_W'(1);
              if (rel_now[NUM_COLUMNS-1]) fsm <= PLAY;
            end
          end
        end
        default: begin
          column_reset <= '1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_game_controller.sv
// ============================================================================
// tb_game_controller
//   Directed vector table plus hand sequences for launch timing, restart,
//   saturation, lives floor and asynchronous reset.
//   Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_controller;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic [2:0] correct = 3'b000;
  logic [2:0] game_over = 3'b000;
  logic [2:0] column_reset;
  logic [3:0] score;
  logic [3:0] lives;
  logic [1:0] state;

  int tests = 0;
  int fails = 0;

  game_controller #(
    .NUM_COLUMNS   (3),
    .SCORE_WIDTH   (4),
    .STAGGER_CYCLES(4),
    .START_LIVES   (2)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .correct     (correct),
    .game_over   (game_over),
    .column_reset(column_reset),
    .score       (score),
    .lives       (lives),
    .state       (state)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] corr;
    logic [2:0] gov;
    logic       st;
    logic [2:0] cr;
    logic [3:0] sc;
    logic [3:0] lv;
    logic [1:0] fs;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [2:0] cr, input logic [3:0] sc,
                       input logic [3:0] lv, input logic [1:0] fs);
    tests++;
    if (column_reset !== cr || score !== sc || lives !== lv || state !== fs) begin
      fails++;
      $display("FAIL %s: got cr=%b score=%0d lives=%0d state=%0d, want cr=%b score=%0d lives=%0d state=%0d",
               name, column_reset, score, lives, state, cr, sc, lv, fs);
    end
  endtask

  // Apply one cycle of inputs at the falling edge; outputs settle by the next one.
  task automatic step(input logic st, input logic [2:0] c, input logic [2:0] g);
    start = st; correct = c; game_over = g;
    @(negedge clock);
    start = 1'b0; correct = 3'b000; game_over = 3'b000;
  endtask

  task automatic reset_cycle();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic start_to_play();
    step(1'b1, 3'b000, 3'b000);
    repeat (9) @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Table starts in PLAY with score 0, lives 2, all columns released.
    vecs[0]  = '{3'b101, 3'b000, 1'b0, 3'b101, 4'd2, 4'd2, 2'd2};
    vecs[1]  = '{3'b000, 3'b000, 1'b0, 3'b000, 4'd2, 4'd2, 2'd2};
    vecs[2]  = '{3'b010, 3'b000, 1'b0, 3'b010, 4'd3, 4'd2, 2'd2};
    vecs[3]  = '{3'b011, 3'b000, 1'b0, 3'b001, 4'd4, 4'd2, 2'd2};
    vecs[4]  = '{3'b111, 3'b000, 1'b0, 3'b110, 4'd6, 4'd2, 2'd2};
    vecs[5]  = '{3'b000, 3'b000, 1'b0, 3'b000, 4'd6, 4'd2, 2'd2};
    vecs[6]  = '{3'b000, 3'b001, 1'b0, 3'b001, 4'd6, 4'd1, 2'd2};
    vecs[7]  = '{3'b000, 3'b000, 1'b0, 3'b000, 4'd6, 4'd1, 2'd2};
    vecs[8]  = '{3'b010, 3'b010, 1'b0, 3'b111, 4'd6, 4'd0, 2'd3};
    vecs[9]  = '{3'b111, 3'b000, 1'b0, 3'b111, 4'd6, 4'd0, 2'd3};
    vecs[10] = '{3'b000, 3'b111, 1'b0, 3'b111, 4'd6, 4'd0, 2'd3};
    vecs[11] = '{3'b000, 3'b000, 1'b1, 3'b111, 4'd0, 4'd2, 2'd1};

    // Reset and idle.
    @(negedge clock);
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_state", 3'b111, 4'd0, 4'd0, 2'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    check("idle_hold", 3'b111, 4'd0, 4'd0, 2'd0);

    // Launch timing: 111, 110, then 100 four cycles later, 000 with PLAY.
    step(1'b1, 3'b000, 3'b000);
    check("start_launch", 3'b111, 4'd0, 4'd2, 2'd1);
    for (int k = 1; k <= 9; k++) begin
      logic [2:0] exp_cr;
      logic [1:0] exp_fs;
      exp_cr = (k >= 9) ? 3'b000 : (k >= 5) ? 3'b100 : 3'b110;
      exp_fs = (k >= 9) ? 2'd2 : 2'd1;
      @(negedge clock);
      check($sformatf("launch_k%0d", k), exp_cr, 4'd0, 4'd2, exp_fs);
    end

    // Vector table.
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].st, vecs[i].corr, vecs[i].gov);
      check($sformatf("vec%0d", i), vecs[i].cr, vecs[i].sc, vecs[i].lv, vecs[i].fs);
    end

    // Start held high keeps restarting; column 0 releases once it drops.
    step(1'b1, 3'b000, 3'b000);
    check("start_held1", 3'b111, 4'd0, 4'd2, 2'd1);
    step(1'b1, 3'b001, 3'b000);
    check("start_held2", 3'b111, 4'd0, 4'd2, 2'd1);
    step(1'b0, 3'b000, 3'b000);
    check("start_drop", 3'b110, 4'd0, 4'd2, 2'd1);
    // Match on the released column during LAUNCH scores and respawns.
    step(1'b0, 3'b011, 3'b000);
    check("launch_hit", 3'b111, 4'd1, 4'd2, 2'd1);

    // Asynchronous reset mid-launch, observed between clock edges.
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", 3'b111, 4'd0, 4'd0, 2'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    check("post_reset_idle", 3'b111, 4'd0, 4'd0, 2'd0);

    // Score saturation at 15.
    start_to_play();
    check("play_again", 3'b000, 4'd0, 4'd2, 2'd2);
    for (int n = 0; n < 14; n++) begin
      step(1'b0, 3'b001, 3'b000);
      @(negedge clock);
    end
    check("score_14", 3'b000, 4'd14, 4'd2, 2'd2);
    step(1'b0, 3'b111, 3'b000);
    check("score_sat", 3'b111, 4'd15, 4'd2, 2'd2);
    step(1'b0, 3'b000, 3'b000);
    check("score_sat_idle", 3'b000, 4'd15, 4'd2, 2'd2);
    step(1'b0, 3'b010, 3'b000);
    check("score_sat_hold", 3'b010, 4'd15, 4'd2, 2'd2);

    // Start beats same-cycle pulses in PLAY.
    @(negedge clock);
    step(1'b1, 3'b111, 3'b111);
    check("start_priority", 3'b111, 4'd0, 4'd2, 2'd1);

    // Three simultaneous misses with two lives floor at zero.
    repeat (9) @(negedge clock);
    check("play_third", 3'b000, 4'd0, 4'd2, 2'd2);
    step(1'b0, 3'b000, 3'b111);
    check("lives_floor", 3'b111, 4'd0, 4'd0, 2'd3);
    step(1'b1, 3'b000, 3'b000);
    check("restart_from_over", 3'b111, 4'd0, 4'd2, 2'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
